cache_controller: RTL and testbench

- Sequences CPU read requests against the direct-mapped instruction/data cache: 1024 sets, 4-word lines, 15-bit word address, 3-bit tag.
- On a hit it returns the cached word.
- On a miss it bursts the 4-word line from main memory, assembles it, drives the cache fill port (cache_write, dataIn1..4), then returns the requested word.
- Sits between the CPU stall/ready interface and the cache array.

---
 rtl/cache_controller_pkg.sv | 22 ++
 rtl/cache_controller_line_fill_buffer.sv | 39 +++
 rtl/cache_controller.sv | 137 +++++++++++++
 tb/tb_cache_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_controller_pkg.sv
// Shared constants and state type for the cache controller slice.
// Address layout: tag [14:12], set index [11:2], word offset [1:0].
package cache_controller_pkg;

    localparam int WORD_LENGTH = 32;
    localparam int SETS        = 1024;
    localparam int IDX_START   = 2;
    localparam int IDX_END     = 11;
    localparam int TAG_START   = 12;
    localparam int TAG_END     = 14;
    localparam int OFF_W       = 2;
    localparam logic VALID     = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_FETCH,
        S_FILL,
        S_RESPOND
    } state_t;

endpackage

// File: rtl/cache_controller_line_fill_buffer.sv
// Four-word line assembly register file.
// Provides one selected word plus all four words in parallel.
module line_fill_buffer
    import cache_controller_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [OFF_W-1:0]  widx,
    input  logic [WORD_W-1:0] wdata,
    input  logic [OFF_W-1:0]  ridx,
    output logic [WORD_W-1:0] rdata,
    output logic [WORD_W-1:0] w0,
    output logic [WORD_W-1:0] w1,
    output logic [WORD_W-1:0] w2,
    output logic [WORD_W-1:0] w3
);

    logic [WORD_W-1:0] words [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) words[i] <= '0;
        end else if (we) begin
            words[widx] <= wdata;
        end
    end

    always_comb begin
        rdata = words[ridx];
        w0    = words[0];
        w1    = words[1];
        w2    = words[2];
        w3    = words[3];
    end

endmodule

// File: rtl/cache_controller.sv
// Read-only direct-mapped cache sequencer: lookup, line burst on miss,
// single-cycle fill strobe, then one-cycle response pulse to the CPU.
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int WORD_W     = WORD_LENGTH,
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic [WORD_W-1:0] cpu_data,
    output logic [ADDR_W-1:0] cache_addr,
    input  logic              cache_hit,
    input  logic [WORD_W-1:0] cache_data,
    output logic              cache_write,
    output logic [WORD_W-1:0] fill_w0,
    output logic [WORD_W-1:0] fill_w1,
    output logic [WORD_W-1:0] fill_w2,
    output logic [WORD_W-1:0] fill_w3,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_data,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    state_t            state, nstate;
    logic [ADDR_W-1:0] req_addr;
    logic [OFF_W-1:0]  word_cnt;
    logic              last_beat;
    logic              buf_we;
    logic [WORD_W-1:0] buf_rdata, buf_w0, buf_w1, buf_w2, buf_w3;
    logic [WORD_W-1:0] hold_w0, hold_w1, hold_w2, hold_w3;

    assign buf_we    = (state == S_FETCH) && mem_ready;
    assign last_beat = (word_cnt == OFF_W'(LINE_WORDS - 1));

    line_fill_buffer #(.WORD_W(WORD_W)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (buf_we),
        .widx  (word_cnt),
        .wdata (mem_data),
        .ridx  (req_addr[OFF_W-1:0]),
        .rdata (buf_rdata),
        .w0    (buf_w0),
        .w1    (buf_w1),
        .w2    (buf_w2),
        .w3    (buf_w3)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:    if (cpu_req) nstate = S_LOOKUP;
            S_LOOKUP:  nstate = cache_hit ? S_RESPOND : S_FETCH;
            S_FETCH:   if (mem_ready && last_beat) nstate = S_FILL;
            S_FILL:    nstate = S_RESPOND;
            S_RESPOND: nstate = S_IDLE;
            default:   nstate = S_IDLE;
        endcase
    end

    // Fill words pass straight from the buffer during FILL and are then held,
    // so the next burst can overwrite the buffer without disturbing fill_w*.
    always_comb begin
        mem_rd      = (state == S_FETCH);
        cache_write = (state == S_FILL);
        cpu_ready   = (state == S_RESPOND);
        fill_w0     = (state == S_FILL) ? buf_w0 : hold_w0;
        fill_w1     = (state == S_FILL) ? buf_w1 : hold_w1;
        fill_w2     = (state == S_FILL) ? buf_w2 : hold_w2;
        fill_w3     = (state == S_FILL) ? buf_w3 : hold_w3;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr   <= '0;
            cache_addr <= '0;
            cpu_data   <= '0;
            mem_addr   <= '0;
            word_cnt   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            hold_w0    <= '0;
            hold_w1    <= '0;
            hold_w2    <= '0;
            hold_w3    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        req_addr   <= cpu_addr;
                        cache_addr <= cpu_addr;
                    end
                end
                S_LOOKUP: begin
                    if (cache_hit) begin
                        cpu_data  <= cache_data;
                        hit_count <= hit_count + 1'b1;
                    end else begin
                        miss_count <= miss_count + 1'b1;
                        word_cnt   <= '0;
                        mem_addr   <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    end
                end
                S_FETCH: begin
                    if (mem_ready && !last_beat) begin
                        word_cnt <= word_cnt + 1'b1;
                        mem_addr <= {req_addr[ADDR_W-1:OFF_W], word_cnt + 1'b1};
                    end
                end
                S_FILL: begin
                    cpu_data   <= buf_rdata;
                    cache_addr <= req_addr;
                    hold_w0    <= buf_w0;
                    hold_w1    <= buf_w1;
                    hold_w2    <= buf_w2;
                    hold_w3    <= buf_w3;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller with a behavioural cache array,
// a memory with configurable stalls, and a line-level hit/miss reference.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [14:0] cpu_addr;
    logic        cpu_ready;
    logic [31:0] cpu_data;
    logic [14:0] cache_addr;
    logic        cache_hit;
    logic [31:0] cache_data;
    logic        cache_write;
    logic [31:0] fill_w0, fill_w1, fill_w2, fill_w3;
    logic        mem_rd;
    logic [14:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [15:0] hit_count, miss_count;

    int total = 0;
    int bad   = 0;

    cache_controller #(.ADDR_W(15), .WORD_W(32), .LINE_WORDS(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_ready(cpu_ready), .cpu_data(cpu_data), .cache_addr(cache_addr),
        .cache_hit(cache_hit), .cache_data(cache_data), .cache_write(cache_write),
        .fill_w0(fill_w0), .fill_w1(fill_w1), .fill_w2(fill_w2), .fill_w3(fill_w3),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [14:0] a);
        return {a, ~a, 2'b10};
    endfunction

    // Behavioural cache array: combinational read, captures fills on negedge.
    logic        cv    [1024];
    logic [2:0]  ctag  [1024];
    logic [31:0] cdata [4096];

    assign cache_hit  = cv[cache_addr[11:2]] && (ctag[cache_addr[11:2]] == cache_addr[14:12]);
    assign cache_data = cdata[cache_addr[11:0]];
    assign mem_data   = memf(mem_addr);

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) cv[i] <= 1'b0;
        end else if (cache_write) begin
            cv[cache_addr[11:2]]          <= 1'b1;
            ctag[cache_addr[11:2]]        <= cache_addr[14:12];
            cdata[{cache_addr[11:2], 2'd0}] <= fill_w0;
            cdata[{cache_addr[11:2], 2'd1}] <= fill_w1;
            cdata[{cache_addr[11:2], 2'd2}] <= fill_w2;
            cdata[{cache_addr[11:2], 2'd3}] <= fill_w3;
        end
    end

    // Reference: which lines the CPU has already been served from, and stats.
    bit          rv   [1024];
    logic [2:0]  rtag [1024];
    int          exp_hits, exp_misses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic [14:0] a, input int stall, input bit noise);
        bit          hit, done;
        int          cyc, writes, rdcyc, beat, left;
        logic [14:0] base;
        hit  = rv[a[11:2]] && (rtag[a[11:2]] == a[14:12]);
        base = {a[14:2], 2'b00};
        cyc = 0; writes = 0; rdcyc = 0; beat = 0; left = stall; done = 1'b0;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = a;
        mem_ready = 1'b0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            cpu_req = (noise && mem_rd) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (cache_write) begin
                writes++;
                check("fill_w0", fill_w0, memf(base));
                check("fill_w1", fill_w1, memf(base + 15'd1));
                check("fill_w2", fill_w2, memf(base + 15'd2));
                check("fill_w3", fill_w3, memf(base + 15'd3));
                check("fill_addr", {17'd0, cache_addr}, {17'd0, a});
            end
            if (mem_rd) begin
                rdcyc++;
                check("mem_addr", {17'd0, mem_addr}, {17'd0, base + 15'(beat)});
                if (left > 0) begin
                    mem_ready = 1'b0;
                    left--;
                end else begin
                    mem_ready = 1'b1;
                    beat++;
                    left = stall;
                end
            end else begin
                mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (cpu_ready) done = 1'b1;
        end
        cpu_req   = 1'b0;
        mem_ready = 1'b0;
        check("ready_seen", {31'd0, done}, 32'd1);
        check("latency", cyc, hit ? 2 : 3 + 4 * (stall + 1));
        check("cpu_data", cpu_data, memf(a));
        check("fill_pulses", writes, hit ? 0 : 1);
        check("mem_rd_cycles", rdcyc, hit ? 0 : 4 * (stall + 1));
        if (hit) exp_hits++;
        else begin
            exp_misses++;
            rv[a[11:2]]   = 1'b1;
            rtag[a[11:2]] = a[14:12];
        end
        check("hit_count", {16'd0, hit_count}, {16'd0, 16'(exp_hits)});
        check("miss_count", {16'd0, miss_count}, {16'd0, 16'(exp_misses)});
        @(negedge clk);
        check("ready_pulse", {31'd0, cpu_ready}, 32'd0);
        check("data_hold", cpu_data, memf(a));
    endtask

    initial begin
        int          beats, cyc;
        logic [14:0] ra;
        rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; mem_ready = 1'b0;
        exp_hits = 0; exp_misses = 0;
        for (int i = 0; i < 1024; i++) rv[i] = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, cpu_ready}, 32'd0);
        check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_cwrite", {31'd0, cache_write}, 32'd0);
        check("rst_hits", {16'd0, hit_count}, 32'd0);
        check("rst_misses", {16'd0, miss_count}, 32'd0);
        check("rst_mem_addr", {17'd0, mem_addr}, 32'd0);
        check("rst_cache_addr", {17'd0, cache_addr}, 32'd0);
        check("rst_cpu_data", cpu_data, 32'd0);
        check("rst_fill_w0", fill_w0, 32'd0);
        rst = 1'b0;

        do_req(15'h1005, 0, 1'b0);   // cold miss
        do_req(15'h1007, 0, 1'b0);   // hit in the same line
        do_req(15'h0010, 3, 1'b0);   // miss with stalled memory

        // Stray mem_ready in IDLE must not start anything.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            check("idle_mem_rd", {31'd0, mem_rd}, 32'd0);
            check("idle_cwrite", {31'd0, cache_write}, 32'd0);
        end
        mem_ready = 1'b0;
        @(negedge clk);
        check("idle_hits", {16'd0, hit_count}, {16'd0, 16'(exp_hits)});
        check("idle_misses", {16'd0, miss_count}, {16'd0, 16'(exp_misses)});

        for (int n = 0; n < 40; n++) begin
            ra = {3'($urandom_range(0, 1)), 10'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            do_req(ra, $urandom_range(0, 2), 1'b1);
        end

        // Hit counter wrap.
        do_req(15'h0123, 0, 1'b0);
        @(negedge clk);
        force dut.hit_count = 16'hFFFF;
        @(negedge clk);
        release dut.hit_count;
        exp_hits = 16'hFFFF;
        do_req(15'h0123, 0, 1'b0);
        check("hit_wrap", {16'd0, hit_count}, 32'd0);
        exp_hits = 0;

        // Reset after two of four beats.
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 15'h2208;
        beats = 0; cyc = 0;
        while (beats < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            cpu_req = 1'b0;
            if (mem_rd) begin
                mem_ready = 1'b1;
                beats++;
            end else mem_ready = 1'b0;
        end
        check("abort_beats", beats, 2);
        @(negedge clk);
        mem_ready = 1'b0;
        check("abort_in_fetch", {31'd0, mem_rd}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("abort_cwrite", {31'd0, cache_write}, 32'd0);
        check("abort_hits", {16'd0, hit_count}, 32'd0);
        check("abort_misses", {16'd0, miss_count}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_hits = 0; exp_misses = 0;
        for (int i = 0; i < 1024; i++) rv[i] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_fill", {31'd0, cache_write}, 32'd0);
        end
        do_req(15'h2208, 1, 1'b0);   // behaves as a cold miss again
        do_req(15'h220B, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

endmodule
